input_skew_buffer: RTL and testbench
====================================

Name: input_skew_buffer

Overview:
- Sits directly downstream of the input router. Consumes its per-row words and valids, and supplies its pop enable.
- Buffers each row in a small FIFO, then issues aligned columns into the systolic array with diagonal skew (row r delayed r cycles).
- Stalls cleanly on array backpressure and drains partial columns at end of context.

Parameters:
- ROW_COUNT, 4, number of router rows / array rows
- DATA_WIDTH, 8, bits per word
- FIFO_DEPTH, 8, entries per row FIFO (power of 2, >= 4)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  enables the block; leaves IDLE when high
- i_reg_clear  in  1  synchronous soft clear, same effect as i_rst
- i_data  in  [ROW_COUNT][DATA_WIDTH]  router row words
- i_data_valid  in  [ROW_COUNT]  per-row push strobes
- i_context_done  in  1  pulse: upstream has produced the whole context
- i_array_ready  in  1  array accepts a skewed beat this cycle
- o_pop_en  out  1  drives router i_pop_en
- o_data  out  [ROW_COUNT][DATA_WIDTH]  skewed row words to the array
- o_data_valid  out  [ROW_COUNT]  per-row valid to the array
- o_drain_done  out  1  one-cycle pulse when context fully drained
- o_overflow  out  1  sticky; a push was dropped on a full FIFO

Behaviour:
- Reset and clear: i_rst or i_reg_clear clears FIFOs, delay lines, context latch and o_overflow, and sets state to IDLE. All outputs are 0 the following cycle. Clear wins over any simultaneous push, issue or context_done.
- Push rules:
  - Row r writes i_data[r] when i_data_valid[r]=1 and state is not DONE.
  - A push is accepted if count<FIFO_DEPTH, or if the FIFO is full and pops in the same cycle.
  - Otherwise the word is dropped and o_overflow is set.
  - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- o_pop_en: registered. It is 1 when state==RUN and every row count <= FIFO_DEPTH-2, giving a 2-slot margin for router pop-to-valid latency.
- Issue:
  - RUN: issue when every FIFO is non-empty and i_array_ready=1.
  - DRAIN: issue when any FIFO is non-empty and i_array_ready=1; empty rows inject valid=0.
  - An issue pops the head of every non-empty FIFO simultaneously.
- Skew delay lines:
  - Row r has r+1 register stages (word+valid).
  - Stages advance only when i_array_ready=1. A non-issue ready cycle injects a bubble (valid=0).
  - When i_array_ready=0, all stages and outputs hold.
  - o_data / o_data_valid are the last stage of each line.
- Latency: with i_array_ready held high, row r output appears r+1 cycles after the issue cycle.
- FSM:
  - IDLE -> RUN when i_en=1.
  - RUN -> DRAIN when the context latch is set. The latch is set by i_context_done in any state except IDLE; a pulse arriving in IDLE is ignored.
  - DRAIN -> DONE when all FIFOs are empty and all delay-line valids are 0.
  - DONE -> IDLE after 1 cycle; o_drain_done=1 during DONE only; the context latch clears.
  - i_en=0 in RUN or DRAIN freezes issue but does not change state. Pushes are still accepted.
- Simultaneous push and pop on one FIFO: count is unchanged and the data order is preserved.

Optional Feature:
- Macro INPUT_SKEW_STATS_EN. When defined, adds port o_stall_count (out, 16 bits).
- o_stall_count counts cycles where i_array_ready=0 and any delay-line valid is 1. It saturates at 16'hFFFF and is cleared by reset/clear.
- Without the macro, the port and counter are absent and there are no other behavioural differences.

Test Plan:
- Reset mid-stream: push 3 words/row, assert i_rst for 1 cycle -> next cycle all outputs 0, counts 0, state IDLE, o_pop_en=0.
- Skew check (ROW_COUNT=4): push column {A0,B0,C0,D0} in one cycle, ready=1 -> A0 valid at issue+1, B0 at +2, C0 at +3, D0 at +4, each valid for 1 cycle.
- Backpressure: stream 6 columns, drop i_array_ready for 3 cycles mid-stream -> outputs hold, no word lost or duplicated, order intact; with INPUT_SKEW_STATS_EN, o_stall_count=3.
- Full/overflow (FIFO_DEPTH=8): push 9 words into row 0 with ready=0 -> o_pop_en falls once count reaches 7, 9th word dropped, o_overflow=1 and stays 1.
- Partial drain: rows 0,1 hold 2 words, rows 2,3 hold 1 word, pulse i_context_done -> 2 issues; second issue has rows 2,3 valid=0; o_drain_done pulses once after row 3's last stage empties, then IDLE.
- Clear collision: i_reg_clear with simultaneous i_data_valid=4'hF and i_context_done -> FIFOs empty, latch clear, no o_drain_done.

Source files
------------

// File: rtl/input_skew_buffer.sv
// input_skew_buffer: per-row FIFOs feeding diagonally skewed columns into a systolic array; optional stall counter under INPUT_SKEW_STATS_EN.
//   i_clk, i_rst, i_reg_clear : clock, sync active-high reset and soft clear (same effect)
//   i_en                     : block enable (leaves IDLE, gates issue)
//   i_data, i_data_valid     : router row words and per-row push strobes
//   i_context_done           : end-of-context pulse from upstream
//   i_array_ready            : array accepts a skewed beat
//   o_pop_en                 : router pop enable (2-slot margin)
//   o_data, o_data_valid     : skewed row words and valids, row r delayed r+1 beats
//   o_drain_done             : one-cycle pulse in DONE
//   o_overflow               : sticky dropped-push flag
//   o_stall_count            : saturating backpressure stall count (INPUT_SKEW_STATS_EN only)
module input_skew_buffer #(
  parameter int ROW_COUNT  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_en,
  input  logic                                 i_reg_clear,
  input  logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] i_data,
  input  logic [ROW_COUNT-1:0]                 i_data_valid,
  input  logic                                 i_context_done,
  input  logic                                 i_array_ready,
  output logic                                 o_pop_en,
  output logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] o_data,
  output logic [ROW_COUNT-1:0]                 o_data_valid,
  output logic                                 o_drain_done,
  output logic                                 o_overflow
`ifdef INPUT_SKEW_STATS_EN
  ,
  output logic [15:0]                          o_stall_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MARGIN = CW'(FIFO_DEPTH - 2);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic r_ctx, r_pop_en, r_overflow;
  logic w_clr, w_issue;
  logic [ROW_COUNT-1:0] w_nonempty, w_pop, w_push, w_drop, w_ok, w_busy;
  assign w_clr = i_rst | i_reg_clear;
  // RUN needs a full column; DRAIN flushes whatever is left, padding empty rows with bubbles
  assign w_issue = i_en && i_array_ready &&
                   ((r_state == RUN && &w_nonempty) || (r_state == DRAIN && |w_nonempty));
  for (genvar g = 0; g < ROW_COUNT; g++) begin : g_row
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wp, r_rp;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_dd [g+1];
    logic [g:0]            r_dv;
    logic                  w_req, w_full;
    assign w_full        = r_cnt == FULL;
    assign w_req         = i_data_valid[g] && r_state != DONE;
    assign w_nonempty[g] = r_cnt != '0;
    assign w_pop[g]      = w_issue && w_nonempty[g];
    // a full FIFO still takes the word when its head leaves in the same cycle
    assign w_push[g]     = w_req && (!w_full || w_pop[g]);
    assign w_drop[g]     = w_req && w_full && !w_pop[g];
    assign w_ok[g]       = r_cnt <= MARGIN;
    assign w_busy[g]     = |r_dv;
    assign o_data[g]       = r_dd[g];
    assign o_data_valid[g] = r_dv[g];
    always_ff @(posedge i_clk)
      if (w_push[g]) r_mem[r_wp] <= i_data[g];
    always_ff @(posedge i_clk) begin
      if (w_clr) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        r_wp  <= w_push[g] ? r_wp + 1'b1 : r_wp;
        r_rp  <= w_pop[g] ? r_rp + 1'b1 : r_rp;
        r_cnt <= r_cnt + CW'(w_push[g]) - CW'(w_pop[g]);
      end
    end
    always_ff @(posedge i_clk) begin
      if (w_clr) begin
        r_dv <= '0;
        r_dd <= '{default: '0};
      end else if (i_array_ready) begin
        for (int k = g; k > 0; k--) begin
          r_dv[k] <= r_dv[k-1];
          r_dd[k] <= r_dd[k-1];
        end
        r_dv[0] <= w_pop[g];
        r_dd[0] <= w_pop[g] ? r_mem[r_rp] : '0;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = i_en ? RUN : IDLE;
      RUN:   w_next = r_ctx ? DRAIN : RUN;
      DRAIN: w_next = (!(|w_nonempty) && !(|w_busy)) ? DONE : DRAIN;
      DONE:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_state    <= IDLE;
      r_ctx      <= 1'b0;
      r_pop_en   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ctx      <= r_state == DONE ? 1'b0 : (r_ctx | (i_context_done && r_state != IDLE));
      r_pop_en   <= r_state == RUN && &w_ok;
      r_overflow <= r_overflow | (|w_drop);
    end
  end
  assign o_pop_en     = r_pop_en;
  assign o_overflow   = r_overflow;
  assign o_drain_done = r_state == DONE;
`ifdef INPUT_SKEW_STATS_EN
  logic [15:0] r_stall;
  always_ff @(posedge i_clk) begin
    if (w_clr) r_stall <= '0;
    else if (!i_array_ready && |w_busy && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end
  assign o_stall_count = r_stall;
`endif
endmodule

// File: tb/tb_input_skew_buffer.sv
// tb_input_skew_buffer: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_input_skew_buffer;
  localparam int R = 4;
  localparam int W = 8;
  localparam int D = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, clr, en, ctx, rdy;
  logic [R-1:0][W-1:0] data;
  logic [R-1:0] valid;
  logic pop_en, drain_done, overflow;
  logic [R-1:0][W-1:0] o_data;
  logic [R-1:0] o_valid;
`ifdef INPUT_SKEW_STATS_EN
  logic [15:0] stall_count;
`endif
  input_skew_buffer #(.ROW_COUNT(R), .DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_reg_clear(clr),
    .i_data(data), .i_data_valid(valid), .i_context_done(ctx), .i_array_ready(rdy),
    .o_pop_en(pop_en), .o_data(o_data), .o_data_valid(o_valid),
    .o_drain_done(drain_done), .o_overflow(overflow)
`ifdef INPUT_SKEW_STATS_EN
    , .o_stall_count(stall_count)
`endif
  );
  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // model: FIFOs are plain queues; m_beats holds one column per ready cycle, newest first,
  // so row r shows the column injected r ready-cycles before the latest one
  logic [W-1:0] m_q [R][$];
  logic [R-1:0][W:0] m_beats [$];
  int m_st;
  bit m_latch, m_ovf, m_pop_en;
  int m_stall;
  task automatic model_clear();
    for (int r = 0; r < R; r++) m_q[r].delete();
    m_beats.delete();
    repeat (R) m_beats.push_back('0);
    m_st = 0; m_latch = 0; m_ovf = 0; m_pop_en = 0; m_stall = 0;
  endtask
  task automatic model_step();
    bit anyne, allne, anyv, issue, okall;
    int nxt;
    logic [R-1:0][W:0] beat;
    if (rst || clr) begin
      model_clear();
      return;
    end
    anyne = 0; allne = 1; anyv = 0; okall = 1;
    for (int r = 0; r < R; r++) begin
      anyne |= m_q[r].size() != 0;
      allne &= m_q[r].size() != 0;
      okall &= m_q[r].size() <= D - 2;
      for (int k = 0; k <= r; k++) anyv |= m_beats[k][r][W];
    end
    issue = en && rdy && ((m_st == 1 && allne) || (m_st == 2 && anyne));
    beat = '0;
    for (int r = 0; r < R; r++)
      if (issue && m_q[r].size() != 0) beat[r] = {1'b1, m_q[r].pop_front()};
    for (int r = 0; r < R; r++)
      if (valid[r] && m_st != 3) begin
        if (m_q[r].size() < D) m_q[r].push_back(data[r]);
        else m_ovf = 1;
      end
    if (!rdy && anyv && m_stall != 65535) m_stall++;
    if (rdy) begin
      m_beats.push_front(beat);
      void'(m_beats.pop_back());
    end
    case (m_st)
      0: nxt = en ? 1 : 0;
      1: nxt = m_latch ? 2 : 1;
      2: nxt = (!anyne && !anyv) ? 3 : 2;
      default: nxt = 0;
    endcase
    m_pop_en = m_st == 1 && okall;
    m_latch = m_st == 3 ? 0 : (m_latch | (ctx && m_st != 0));
    m_st = nxt;
  endtask
  task automatic check_outputs();
    logic [R-1:0] ev;
    for (int r = 0; r < R; r++) ev[r] = m_beats[r][r][W];
    check("pop_en", 32'(pop_en), 32'(m_pop_en));
    check("drain_done", 32'(drain_done), 32'(m_st == 3));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("valid", 32'(o_valid), 32'(ev));
    for (int r = 0; r < R; r++)
      if (ev[r]) check($sformatf("data_row%0d", r), 32'(o_data[r]), 32'(m_beats[r][r][W-1:0]));
`ifdef INPUT_SKEW_STATS_EN
    check("stall_count", 32'(stall_count), 32'(m_stall));
`endif
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    for (int r = 0; r < R; r++) data[r] = W'($urandom);
  endtask
  task automatic idle(input int n);
    valid = '0; ctx = 0;
    repeat (n) tick();
  endtask
  int pulses;
  initial begin
    rst = 1; clr = 0; en = 0; ctx = 0; rdy = 0; valid = '0; data = '0;
    model_clear();
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    check("reset_pop_en", 32'(pop_en), 32'd0);
    check("reset_valid", 32'(o_valid), 32'd0);
    // reset mid-stream
    en = 1; valid = '1;
    repeat (3) tick();
    valid = '0; rst = 1;
    tick();
    rst = 0;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_pop_en", 32'(pop_en), 32'd0);
    idle(3);
    // skew: single column with ready held high
    rdy = 1; valid = '1;
    tick();
    idle(7);
    // backpressure: six columns with three stalled cycles in the middle
    for (int c = 0; c < 9; c++) begin
      valid = c < 6 ? '1 : '0;
      rdy = !(c >= 3 && c <= 5);
      tick();
    end
    rdy = 1;
    idle(8);
    // full/overflow on row 0 with the array stalled
    rdy = 0;
    for (int c = 0; c < 9; c++) begin
      valid = 4'b0001;
      tick();
    end
    check("ovf_sticky", 32'(overflow), 32'd1);
    idle(2);
    rdy = 1;
    idle(12);
    // partial drain: rows 0,1 get two words, rows 2,3 one word
    clr = 1; tick(); clr = 0;
    rdy = 0; en = 1;
    valid = 4'b1111; tick();
    valid = 4'b0011; tick();
    valid = '0; ctx = 1; tick();
    ctx = 0; rdy = 1;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      pulses += int'(drain_done);
    end
    check("drain_pulses", 32'(pulses), 32'd1);
    // clear colliding with pushes and context_done
    valid = '1; ctx = 1; clr = 1;
    tick();
    clr = 0; valid = '0; ctx = 0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      pulses += int'(drain_done);
    end
    check("clr_no_drain", 32'(pulses), 32'd0);
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(999) < 2;
      clr = $urandom_range(999) < 3;
      en = $urandom_range(99) < 90;
      rdy = $urandom_range(99) < 70;
      ctx = $urandom_range(99) < 2;
      for (int r = 0; r < R; r++) valid[r] = $urandom_range(99) < ((c / 500) % 2 ? 60 : 25);
      tick();
    end
    rst = 0; clr = 0;
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
